alu_arbiter: RTL and testbench

Shares one combinational 32-bit ALU (and/or/add/sub/nor/nand/slt) between two independent requesters, e.g. the EX stage and a multi-cycle helper unit. Requests arrive on valid/ready ports, a round-robin arbiter grants one per operation, and a three-state FSM registers operands, drives the ALU, captures result and flags, and returns them on the granted port's response channel. Exactly one operation is in flight at a time.

---
 rtl/alu_arbiter_if.sv | 32 +++
 rtl/alu_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request/response channels between requesters and alu_arbiter.
// master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]      req_valid_i;
  logic [NREQ-1:0]      req_ready_o;
  logic [4*NREQ-1:0]    req_op_i;
  logic [32*NREQ-1:0]   req_a_i;
  logic [32*NREQ-1:0]   req_b_i;
  logic [NREQ-1:0]      rsp_valid_o;
  logic [NREQ-1:0]      rsp_ready_i;
  logic [31:0]          rsp_result_o;
  logic                 rsp_zero_o;
  logic                 rsp_cout_o;
  logic                 rsp_ovf_o;
  logic                 rsp_err_o;

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i,
    input  rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_result_o,
    output rsp_zero_o, rsp_cout_o, rsp_ovf_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i,
    output rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_result_o,
    input  rsp_zero_o, rsp_cout_o, rsp_ovf_o, rsp_err_o
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Optional opcode checking: define ALU_ARB_OPCHK_EN.
module alu_arbiter #(
  parameter int NREQ = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  alu_arbiter_if.slave bus,
  output logic        alu_rst_n_o,
  output logic [31:0] alu_src1_o,
  output logic [31:0] alu_src2_o,
  output logic [3:0]  alu_ctrl_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_zero_i,
  input  logic        alu_cout_i,
  input  logic        alu_ovf_i
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t            r_state;
  logic              r_prio;
  logic              r_gnt;
  logic [NREQ-1:0]   r_rsp_valid;
  logic [31:0]       r_src1;
  logic [31:0]       r_src2;
  logic [3:0]        r_ctrl;
  logic [31:0]       r_result;
  logic              r_zero;
  logic              r_cout;
  logic              r_ovf;

  logic              w_gnt;
  logic              w_acc;
  logic [3:0]        w_op;
  logic [31:0]       w_a;
  logic [31:0]       w_b;

  // prio is tried first; fall back to the other port
  assign w_gnt = bus.req_valid_i[r_prio] ? r_prio : ~r_prio;
  assign w_acc = (r_state == S_IDLE) && (|bus.req_valid_i);
  assign w_op  = w_gnt ? bus.req_op_i[7:4]  : bus.req_op_i[3:0];
  assign w_a   = w_gnt ? bus.req_a_i[63:32] : bus.req_a_i[31:0];
  assign w_b   = w_gnt ? bus.req_b_i[63:32] : bus.req_b_i[31:0];

  assign bus.req_ready_o = !w_acc ? 2'b00 :
                           (w_gnt ? 2'b10 : 2'b01);

  assign alu_rst_n_o      = ~rst_i;
  assign alu_src1_o       = r_src1;
  assign alu_src2_o       = r_src2;
  assign alu_ctrl_o       = r_ctrl;
  assign bus.rsp_valid_o  = r_rsp_valid;
  assign bus.rsp_result_o = r_result;
  assign bus.rsp_zero_o   = r_zero;
  assign bus.rsp_cout_o   = r_cout;
  assign bus.rsp_ovf_o    = r_ovf;

`ifdef ALU_ARB_OPCHK_EN
  logic w_legal;
  logic r_bad;
  logic r_err;

  always_comb begin
    w_legal = 1'b0;
    unique case (w_op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110,
      4'b1100, 4'b1101, 4'b0111: w_legal = 1'b1;
      default:                   w_legal = 1'b0;
    endcase
  end

  assign bus.rsp_err_o = r_err;
`else
  assign bus.rsp_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_prio      <= 1'b0;
      r_gnt       <= 1'b0;
      r_rsp_valid <= '0;
      r_src1      <= '0;
      r_src2      <= '0;
      r_ctrl      <= 4'b0010;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
`ifdef ALU_ARB_OPCHK_EN
      r_bad       <= 1'b0;
      r_err       <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_gnt   <= w_gnt;
            r_src1  <= w_a;
            r_src2  <= w_b;
`ifdef ALU_ARB_OPCHK_EN
            // illegal codes never reach the ALU
            if (w_legal) r_ctrl <= w_op;
            r_bad   <= ~w_legal;
`else
            r_ctrl  <= w_op;
`endif
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
`ifdef ALU_ARB_OPCHK_EN
          r_result <= r_bad ? 32'd0 : alu_result_i;
          r_zero   <= ~r_bad & alu_zero_i;
          r_cout   <= ~r_bad & alu_cout_i;
          r_ovf    <= ~r_bad & alu_ovf_i;
          r_err    <= r_bad;
`else
          r_result <= alu_result_i;
          r_zero   <= alu_zero_i;
          r_cout   <= alu_cout_i;
          r_ovf    <= alu_ovf_i;
`endif
          r_rsp_valid <= r_gnt ? 2'b10 : 2'b01;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready_i[r_gnt]) begin
            r_rsp_valid <= '0;
            r_prio      <= ~r_gnt;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: ALU model, vector table, scoreboard
// and hand-written sequences for latency, fairness, stall, reset.
module tb_alu_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        alu_rst_n_o;
  logic [31:0] alu_src1_o;
  logic [31:0] alu_src2_o;
  logic [3:0]  alu_ctrl_o;
  logic [31:0] alu_result_i;
  logic        alu_zero_i;
  logic        alu_cout_i;
  logic        alu_ovf_i;

  alu_arbiter_if #(.NREQ(2)) bus ();

  alu_arbiter #(.NREQ(2)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .bus          (bus.slave),
    .alu_rst_n_o  (alu_rst_n_o),
    .alu_src1_o   (alu_src1_o),
    .alu_src2_o   (alu_src2_o),
    .alu_ctrl_o   (alu_ctrl_o),
    .alu_result_i (alu_result_i),
    .alu_zero_i   (alu_zero_i),
    .alu_cout_i   (alu_cout_i),
    .alu_ovf_i    (alu_ovf_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
    logic        e;
  } vec_t;

  typedef struct {
    int   port;
    vec_t v;
  } sb_t;

  int   checks   = 0;
  int   failures = 0;
  vec_t tbl [12];
  vec_t cur [2];
  sb_t  sb [$];
  int   gq [$];

  function automatic logic [34:0] alu_f(
    input logic [3:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [32:0] s;
    logic [31:0] r;
    logic        c;
    logic        v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'b0110: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0];
        c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'b1100: r = ~(a | b);
      4'b1101: r = ~(a & b);
      4'b0111: r = {31'd0, $signed(a) < $signed(b)};
      default: r = a ^ b;
    endcase
    return {v, c, (r == 32'd0), r};
  endfunction

  always_comb begin
    {alu_ovf_i, alu_cout_i, alu_zero_i, alu_result_i} =
      alu_f(alu_ctrl_o, alu_src1_o, alu_src2_o);
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // scoreboard: push on accept, pop on consume
  always @(negedge clk_i) begin
    if (rst_i) begin
      sb.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (bus.req_valid_i[k] && bus.req_ready_o[k]) begin
          sb.push_back('{k, cur[k]});
          gq.push_back(k);
        end
        if (bus.rsp_valid_o[k] && bus.rsp_ready_i[k]) begin
          if (sb.size() == 0) begin
            chk("rsp_unexpected", 64'(k), 64'hFF);
          end else begin
            sb_t it;
            it = sb.pop_front();
            chk("rsp_port", 64'(k), 64'(it.port));
            chk("rsp_data",
                {28'd0, bus.rsp_result_o, bus.rsp_zero_o,
                 bus.rsp_cout_o, bus.rsp_ovf_o, bus.rsp_err_o},
                {28'd0, it.v.res, it.v.z, it.v.c,
                 it.v.v, it.v.e});
          end
        end
      end
    end
  end

  task automatic set_port(input int p, input vec_t v);
    cur[p] = v;
    if (p == 0) begin
      bus.req_op_i[3:0]  = v.op;
      bus.req_a_i[31:0]  = v.a;
      bus.req_b_i[31:0]  = v.b;
    end else begin
      bus.req_op_i[7:4]  = v.op;
      bus.req_a_i[63:32] = v.a;
      bus.req_b_i[63:32] = v.b;
    end
  endtask

  task automatic do_req(input int p, input vec_t v);
    bit ok;
    ok = 1'b0;
    @(posedge clk_i); #1;
    set_port(p, v);
    bus.req_valid_i[p] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (bus.req_ready_o[p]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("req_timeout", 64'd0, 64'd1);
    @(posedge clk_i); #1;
    bus.req_valid_i[p] = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 30; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk_i);
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_rsp(input logic [1:0] exp);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if (bus.rsp_valid_o == exp) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("rsp_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    bus.req_valid_i = 2'b00;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_rdy"},  64'(bus.req_ready_o), 64'd0);
    chk({nm, "_rval"}, 64'(bus.rsp_valid_o), 64'd0);
    chk({nm, "_ctrl"}, 64'(alu_ctrl_o), 64'h2);
    chk({nm, "_src"},  {alu_src1_o, alu_src2_o}, 64'd0);
    chk({nm, "_rsp"},
        {28'd0, bus.rsp_result_o, bus.rsp_zero_o,
         bus.rsp_cout_o, bus.rsp_ovf_o, bus.rsp_err_o},
        64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{4'b0110, 32'd5, 32'd7,
                32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{4'b0010, 32'd1, 32'd1,
                32'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{4'b0111, 32'hFFFFFFFF, 32'd1,
                32'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{4'b0010, 32'h7FFFFFFF, 32'd1,
                32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{4'b0000, 32'hF0F0F0F0, 32'h0F0F0F0F,
                32'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{4'b1100, 32'd0, 32'd0,
                32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{4'b0001, 32'h12340000, 32'h00005678,
                32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{4'b1101, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{4'b0110, 32'd3, 32'd3,
                32'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{4'b0010, 32'hFFFFFFFF, 32'd1,
                32'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{4'b0110, 32'h80000000, 32'd1,
                32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0};
`ifdef ALU_ARB_OPCHK_EN
    tbl[11] = '{4'b1111, 32'd5, 32'd6,
                32'd0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    // unchecked: bench ALU model yields a^b for unknown codes
    tbl[11] = '{4'b1111, 32'd5, 32'd6,
                32'd3, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

    bus.req_valid_i = 2'b00;
    bus.req_op_i    = '0;
    bus.req_a_i     = '0;
    bus.req_b_i     = '0;
    bus.rsp_ready_i = 2'b11;

    // reset values and basic latency
    do_reset();
    @(negedge clk_i);
    chk_reset_vals("reset");
    chk("alu_rst_n", 64'(alu_rst_n_o), 64'd1);
    @(posedge clk_i); #1;
    set_port(0, tbl[0]);
    bus.req_valid_i = 2'b01;
    @(negedge clk_i);
    chk("lat_c0_rdy", 64'(bus.req_ready_o), 64'h1);
    @(posedge clk_i); #1;
    bus.req_valid_i = 2'b00;
    @(negedge clk_i);
    chk("lat_c1_rval", 64'(bus.rsp_valid_o), 64'h0);
    chk("lat_c1_alu", {alu_ctrl_o, alu_src1_o, alu_src2_o},
        {4'b0110, 32'd5, 32'd7});
    @(negedge clk_i);
    chk("lat_c2_rval", 64'(bus.rsp_valid_o), 64'h1);
    @(negedge clk_i);
    chk("lat_c3_rval", 64'(bus.rsp_valid_o), 64'h0);
    drain();

    // table vectors, alternating ports
    for (int i = 0; i < 12; i++) begin
      do_req(i % 2, tbl[i]);
      drain();
    end

    // both continuously valid: grants alternate from port 0
    do_reset();
    gq.delete();
    @(posedge clk_i); #1;
    set_port(0, tbl[1]);
    set_port(1, tbl[2]);
    bus.req_valid_i = 2'b11;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk_i);
      if (gq.size() >= 4) break;
    end
    @(posedge clk_i); #1;
    bus.req_valid_i = 2'b00;
    chk("rr_count", 64'(gq.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < gq.size())
        chk("rr_grant", 64'(gq[k]), 64'(k % 2));
    end
    drain();

    // response stall on port1 with port0 waiting
    bus.rsp_ready_i = 2'b00;
    @(posedge clk_i); #1;
    set_port(1, tbl[3]);
    bus.req_valid_i = 2'b10;
    @(negedge clk_i);
    chk("stall_acc", 64'(bus.req_ready_o), 64'h2);
    @(posedge clk_i); #1;
    set_port(0, tbl[4]);
    bus.req_valid_i = 2'b01;
    wait_rsp(2'b10);
    for (int k = 0; k < 5; k++) begin
      chk("stall_hold",
          {27'd0, bus.rsp_valid_o, bus.req_ready_o,
           bus.rsp_result_o, bus.rsp_ovf_o},
          {27'd0, 2'b10, 2'b00, 32'h80000000, 1'b1});
      @(negedge clk_i);
    end
    @(posedge clk_i); #1;
    bus.rsp_ready_i = 2'b01;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("stall_other_rdy", 64'(bus.rsp_valid_o), 64'h2);
    @(posedge clk_i); #1;
    bus.rsp_ready_i = 2'b10;
    @(negedge clk_i);
    chk("consume_no_acc", 64'(bus.req_ready_o), 64'h0);
    @(negedge clk_i);
    chk("resume_acc", 64'(bus.req_ready_o), 64'h1);
    @(posedge clk_i); #1;
    bus.req_valid_i = 2'b00;
    bus.rsp_ready_i = 2'b11;
    drain();

    // reset during EXEC discards op; prio returns to port 0
    @(posedge clk_i); #1;
    set_port(1, tbl[6]);
    bus.req_valid_i = 2'b10;
    @(negedge clk_i);
    chk("rst_acc", 64'(bus.req_ready_o), 64'h2);
    @(posedge clk_i); #1;
    bus.req_valid_i = 2'b00;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk_reset_vals("rst_exec");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("rst_no_rsp", 64'(bus.rsp_valid_o), 64'h0);
    end
    @(posedge clk_i); #1;
    set_port(0, tbl[5]);
    set_port(1, tbl[7]);
    bus.req_valid_i = 2'b11;
    @(negedge clk_i);
    chk("rst_prio0", 64'(bus.req_ready_o), 64'h1);
    @(posedge clk_i); #1;
    bus.req_valid_i = 2'b10;
    wait_rsp(2'b10);
    @(posedge clk_i); #1;
    bus.req_valid_i = 2'b00;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
